// File: rtl/dec_sel_pkg.sv
// rtl/dec_sel_pkg.sv - shared modes, FSM states and code-sequence helpers for dec_sel_sequencer
package dec_sel_pkg;

  typedef enum logic [1:0] {
    MODE_BIN_UP = 2'b00,
    MODE_GRAY   = 2'b01,
    MODE_BIN_DN = 2'b10,
    MODE_LFSR   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Feedback taps for x^4 + x^3 + 1 (bits 3 and 2 of a left-shifting register)
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [1:0] first_code(input mode_e m, input logic [1:0] lfsr_code);
    case (m)
      MODE_BIN_DN: return 2'b11;
      MODE_LFSR:   return lfsr_code;
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] next_code(input mode_e m, input logic [1:0] c,
                                           input logic [1:0] lfsr_next_code);
    case (m)
      MODE_BIN_UP: return c + 2'd1;
      MODE_GRAY: begin
        case (c)
          2'b00:   return 2'b01;
          2'b01:   return 2'b11;
          2'b11:   return 2'b10;
          default: return 2'b00;
        endcase
      end
      MODE_BIN_DN: return c - 2'd1;
      default:     return lfsr_next_code;
    endcase
  endfunction

endpackage

// File: rtl/dec_sel_sequencer_if.sv
// rtl/dec_sel_sequencer_if.sv - run-control and decoder-select bundle for dec_sel_sequencer
interface dec_sel_sequencer_if #(
  parameter int DW = 8,
  parameter int CW = 16
);
  logic          START;
  logic          STOP;
  logic [1:0]    MODE;
  logic [DW-1:0] DWELL;
  logic [CW-1:0] LEN;
  logic          IN1;
  logic          IN2;
  logic          VALID;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] STEP_CNT;
`ifdef DEC_SEL_SEQUENCER_CHECK_EN
  logic [3:0]    Q_FB;
  logic          MISMATCH;
`endif

  modport master (
    output START, STOP, MODE, DWELL, LEN,
`ifdef DEC_SEL_SEQUENCER_CHECK_EN
    output Q_FB,
    input  MISMATCH,
`endif
    input  IN1, IN2, VALID, BUSY, DONE, STEP_CNT
  );

  modport slave (
    input  START, STOP, MODE, DWELL, LEN,
`ifdef DEC_SEL_SEQUENCER_CHECK_EN
    input  Q_FB,
    output MISMATCH,
`endif
    output IN1, IN2, VALID, BUSY, DONE, STEP_CNT
  );
endinterface

// File: rtl/dec_sel_lfsr4.sv
// rtl/dec_sel_lfsr4.sv - 4-bit Fibonacci LFSR, loads SEED on reset and shifts on i_adv
module dec_sel_lfsr4
  import dec_sel_pkg::*;
#(
  parameter logic [3:0] SEED = 4'h1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_adv,
  output logic [1:0] o_code,
  output logic [1:0] o_next_code
);
  // An all-zero seed would lock the register, so it is replaced by 1
  localparam logic [3:0] SEED_EFF = (SEED == 4'h0) ? 4'h1 : SEED;

  logic [3:0] r_state;
  logic [3:0] w_next;

  assign w_next      = lfsr_step(r_state);
  assign o_code      = r_state[1:0];
  assign o_next_code = w_next[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= SEED_EFF;
    else if (i_adv) r_state <= w_next;
  end
endmodule

// File: rtl/dec_sel_sequencer.sv
// rtl/dec_sel_sequencer.sv - programmable IN1/IN2 code sequencer for the 2-to-4 decoder cell
// Optional decoder-output checker enabled by DEC_SEL_SEQUENCER_CHECK_EN.
module dec_sel_sequencer
  import dec_sel_pkg::*;
#(
  parameter int         DW        = 8,
  parameter int         CW        = 16,
  parameter logic [3:0] LFSR_SEED = 4'h1
) (
  input logic                CLK,
  input logic                RSTB,
  dec_sel_sequencer_if.slave bus
);
  state_e        r_state;
  mode_e         r_mode;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] r_dcnt;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_step;
  logic [1:0]    r_code;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  logic       w_start;
  logic       w_last;
  logic       w_adv;
  logic [1:0] w_lfsr_code;
  logic [1:0] w_lfsr_next_code;

  assign w_start = (r_state == ST_IDLE) && bus.START && !bus.STOP;
  assign w_last  = (r_len != '0) && (r_step == r_len);
  assign w_adv   = (r_state == ST_RUN) && !bus.STOP && (r_dcnt == '0) && !w_last;

  dec_sel_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk         (CLK),
    .rst_n       (RSTB),
    .i_adv       (w_adv && (r_mode == MODE_LFSR)),
    .o_code      (w_lfsr_code),
    .o_next_code (w_lfsr_next_code)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_BIN_UP;
      r_dwell <= '0;
      r_dcnt  <= '0;
      r_len   <= '0;
      r_step  <= '0;
      r_code  <= 2'b00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_mode  <= mode_e'(bus.MODE);
            r_dwell <= bus.DWELL;
            r_dcnt  <= bus.DWELL;
            r_len   <= bus.LEN;
            r_step  <= {{(CW-1){1'b0}}, 1'b1};
            r_code  <= first_code(mode_e'(bus.MODE), w_lfsr_code);
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          // Abort wins over dwell expiry and never produces DONE
          if (bus.STOP) begin
            r_state <= ST_IDLE;
            r_code  <= 2'b00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - 1'b1;
          end else if (w_last) begin
            r_state <= ST_FIN;
            r_code  <= 2'b00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_code <= next_code(r_mode, r_code, w_lfsr_next_code);
            r_dcnt <= r_dwell;
            r_step <= r_step + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.IN1      = r_code[1];
  assign bus.IN2      = r_code[0];
  assign bus.VALID    = r_valid;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.STEP_CNT = r_step;

`ifdef DEC_SEL_SEQUENCER_CHECK_EN
  // Q_FB is compared against the code that was on IN1/IN2 one cycle earlier
  logic       r_prev_valid;
  logic [1:0] r_prev_code;
  logic       r_mismatch;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_prev_valid <= 1'b0;
      r_prev_code  <= 2'b00;
      r_mismatch   <= 1'b0;
    end else begin
      r_prev_valid <= r_valid;
      r_prev_code  <= r_code;
      if (w_start)
        r_mismatch <= 1'b0;
      else if (r_prev_valid && (bus.Q_FB != (4'b0001 << r_prev_code)))
        r_mismatch <= 1'b1;
    end
  end

  assign bus.MISMATCH = r_mismatch;
`endif
endmodule

// File: tb/tb_dec_sel_sequencer.sv
// tb/tb_dec_sel_sequencer.sv - directed self-checking bench for dec_sel_sequencer
module tb_dec_sel_sequencer;
  logic CLK = 1'b0;
  logic RSTB;
  always #5 CLK = ~CLK;

  dec_sel_sequencer_if #(.DW(8), .CW(16)) bus ();
  dec_sel_sequencer #(.DW(8), .CW(16), .LFSR_SEED(4'h1)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] code();
    return {bus.IN1, bus.IN2};
  endfunction

`ifdef DEC_SEL_SEQUENCER_CHECK_EN
  logic       force_q;
  logic [3:0] q_model;
  always @(posedge CLK) q_model <= 4'b0001 << {bus.IN1, bus.IN2};
  assign bus.Q_FB = force_q ? 4'b0001 : q_model;
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] gray_exp [5];
    logic [1:0] lfsr_exp [15];
    gray_exp = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    lfsr_exp = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10,
                 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
`ifdef DEC_SEL_SEQUENCER_CHECK_EN
    force_q = 1'b0;
`endif
    RSTB = 1'b0;
    bus.START = 1'b0; bus.STOP = 1'b0; bus.MODE = 2'b00; bus.DWELL = 8'd0; bus.LEN = 16'd0;
    tick(); tick();
    chk("rst_code", 32'(code()), 0);
    chk("rst_valid", 32'(bus.VALID), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_step", 32'(bus.STEP_CNT), 0);
    RSTB = 1'b1;
    tick();

    // binary up, DWELL=0, LEN=4
    bus.MODE = 2'b00; bus.DWELL = 8'd0; bus.LEN = 16'd4; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("up_code", 32'(code()), i);
      chk("up_valid", 32'(bus.VALID), 1);
      chk("up_step", 32'(bus.STEP_CNT), i + 1);
      tick();
    end
    chk("up_done", 32'(bus.DONE), 1);
    chk("up_fin_valid", 32'(bus.VALID), 0);
    chk("up_fin_step", 32'(bus.STEP_CNT), 4);
    tick();
    chk("up_done_clr", 32'(bus.DONE), 0);
    chk("up_step_hold", 32'(bus.STEP_CNT), 4);

    // Gray, DWELL=2, LEN=5
    bus.MODE = 2'b01; bus.DWELL = 8'd2; bus.LEN = 16'd5; bus.START = 1'b1;
    tick();
    bus.START = 1'b0; bus.MODE = 2'b10; bus.DWELL = 8'd7; bus.LEN = 16'd1;
    for (int i = 0; i < 15; i++) begin
      chk("gray_code", 32'(code()), 32'(gray_exp[i / 3]));
      chk("gray_nodone", 32'(bus.DONE), 0);
      tick();
    end
    chk("gray_done", 32'(bus.DONE), 1);
    chk("gray_step", 32'(bus.STEP_CNT), 5);
    tick();

    // binary down, DWELL=1, free-run, STOP at cycle 9
    bus.MODE = 2'b10; bus.DWELL = 8'd1; bus.LEN = 16'd0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("dn_code", 32'(code()), 32'((3 - (i / 2)) & 3));
      chk("dn_busy", 32'(bus.BUSY), 1);
      if (i < 8) tick();
    end
    chk("dn_step9", 32'(bus.STEP_CNT), 5);
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    chk("dn_stop_valid", 32'(bus.VALID), 0);
    chk("dn_stop_code", 32'(code()), 0);
    chk("dn_stop_done", 32'(bus.DONE), 0);
    chk("dn_stop_busy", 32'(bus.BUSY), 0);
    tick();
    chk("dn_stop_done2", 32'(bus.DONE), 0);

    // asynchronous reset in the middle of a run
    bus.MODE = 2'b00; bus.DWELL = 8'd3; bus.LEN = 16'd0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_code", 32'(code()), 1);
    #2 RSTB = 1'b0;
    #1;
    chk("async_valid", 32'(bus.VALID), 0);
    chk("async_busy", 32'(bus.BUSY), 0);
    chk("async_code", 32'(code()), 0);
    chk("async_step", 32'(bus.STEP_CNT), 0);
    tick();
    RSTB = 1'b1;
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("restart_code", 32'(code()), 0);
    chk("restart_valid", 32'(bus.VALID), 1);
    chk("restart_step", 32'(bus.STEP_CNT), 1);
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;

    // LFSR from seed 1, DWELL=0, LEN=15, START pulse mid-run ignored
    bus.MODE = 2'b11; bus.DWELL = 8'd0; bus.LEN = 16'd15; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("lfsr_code", 32'(code()), 32'(lfsr_exp[i]));
      bus.START = (i == 3);
      tick();
    end
    bus.START = 1'b0;
    chk("lfsr_done", 32'(bus.DONE), 1);
    chk("lfsr_step", 32'(bus.STEP_CNT), 15);
    tick();

    // START with STOP in IDLE stays idle
    bus.START = 1'b1; bus.STOP = 1'b1;
    tick();
    bus.START = 1'b0; bus.STOP = 1'b0;
    chk("startstop_valid", 32'(bus.VALID), 0);
    chk("startstop_busy", 32'(bus.BUSY), 0);
    tick();
    chk("startstop_busy2", 32'(bus.BUSY), 0);

    // maximum DWELL with LEN=1: one code held 256 cycles
    bus.MODE = 2'b00; bus.DWELL = 8'hFF; bus.LEN = 16'd1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 0 || i == 255) chk("maxdw_valid", 32'(bus.VALID), 1);
      chk("maxdw_nodone", 32'(bus.DONE), 0);
      tick();
    end
    chk("maxdw_done", 32'(bus.DONE), 1);
    chk("maxdw_step", 32'(bus.STEP_CNT), 1);
    tick();

`ifdef DEC_SEL_SEQUENCER_CHECK_EN
    bus.MODE = 2'b00; bus.DWELL = 8'd0; bus.LEN = 16'd0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("chk_clean", 32'(bus.MISMATCH), 0);
    while (code() != 2'b10) tick();
    force_q = 1'b1;
    tick(); tick();
    force_q = 1'b0;
    chk("chk_set", 32'(bus.MISMATCH), 1);
    tick(); tick();
    chk("chk_sticky", 32'(bus.MISMATCH), 1);
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("chk_clear", 32'(bus.MISMATCH), 0);
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dec_sel_sequencer.md
Name: dec_sel_sequencer

Overview:
Sequential code generator directly upstream of the 2-to-4 decoder cell in the power-test harness; drives the decoder's IN1/IN2 select pair with programmable code sequences and dwell times, so decoder switching activity can be characterised per transition pattern. Run control is a START/STOP handshake with a DONE pulse. An optional checker consumes the decoder's Q0..Q3 outputs and flags any mismatch.

Parameters:
DW, 8, width of DWELL (extra cycles each code is held)
CW, 16, width of LEN and STEP_CNT
LFSR_SEED, 4'h1, initial 4-bit LFSR state for pseudo-random mode (value 0 is replaced by 4'h1)

Ports:
CLK  in  1  clock, rising edge
RSTB  in  1  asynchronous active-low reset
START  in  1  single-cycle run request; sampled only in IDLE
STOP  in  1  abort request; sampled in RUN and in IDLE
MODE  in  2  sequence select: 00 binary up, 01 Gray, 10 binary down, 11 LFSR
DWELL  in  DW  each code is held DWELL+1 cycles
LEN  in  CW  number of codes per run; 0 = free-run until STOP
IN1  out  1  decoder select MSB (registered)
IN2  out  1  decoder select LSB (registered)
VALID  out  1  IN1/IN2 carry a sequence code
BUSY  out  1  run in progress
DONE  out  1  one-cycle pulse on normal completion
STEP_CNT  out  CW  codes presented in the current run (wraps mod 2^CW)

Behaviour:
- Reset (RSTB low, async): state IDLE; IN1=IN2=0, VALID=0, BUSY=0, DONE=0, STEP_CNT=0, LFSR=seed. All outputs are registered.
- FSM states: IDLE, RUN, FIN.
- IDLE: START=1 and STOP=0 -> next edge enters RUN. MODE, DWELL and LEN are captured. First code is presented: 00 for modes 00/01, 11 for mode 10, LFSR[1:0] for mode 11. VALID=1, BUSY=1, STEP_CNT=1, dwell counter=DWELL, remaining=LEN. START together with STOP in IDLE: stay IDLE.
- RUN: dwell counter decrements each cycle. At 0 the code advances on the next edge, the dwell counter reloads, and STEP_CNT increments. The first code therefore appears 1 cycle after START, and each code is held exactly DWELL+1 cycles.
- Sequences:
  - binary up: 00,01,10,11,00...
  - Gray: 00,01,11,10,00...
  - binary down: 11,10,01,00,11...
  - LFSR: 4-bit Fibonacci, taps x^4+x^3+1, shifts once per advance; code = LFSR[1:0].
- Completion (LEN!=0): when the dwell of code number LEN expires, go to FIN instead of advancing. FIN lasts 1 cycle: DONE=1, VALID=0, BUSY=0, IN1=IN2=0. Then IDLE. STEP_CNT holds its final value until the next START.
- STOP in RUN: next edge goes to IDLE. VALID=0, BUSY=0, IN1=IN2=0, no DONE pulse. STOP has priority over dwell expiry in the same cycle.
- START during RUN or FIN is ignored. Captured MODE/DWELL/LEN changes mid-run have no effect.
- DWELL=0: the code advances every cycle. DWELL=2^DW-1 is supported without overflow.
- LEN=0: free-run with no DONE pulse. STEP_CNT wraps silently.
- The LFSR is not reset between runs; it continues from its last state.

Optional Feature:
DEC_SEL_SEQUENCER_CHECK_EN
- Defined: adds input Q_FB[3:0] (decoder outputs Q3..Q0) and output MISMATCH (1 bit, sticky).
- While VALID was 1 in the previous cycle, Q_FB must equal the one-hot decode of the previous cycle's {IN1,IN2} (Q0 for 00 ... Q3 for 11). Any difference sets MISMATCH.
- MISMATCH clears on reset or on an accepted START.
- Not defined: no extra ports, no checker logic.

Decomposition:
- Shared package dec_sel_pkg:
  - mode encodings (MODE_BIN_UP, MODE_GRAY, MODE_BIN_DN, MODE_LFSR)
  - FSM state enum
  - LFSR tap constant
  - function returning the next 2-bit code for (mode, code, lfsr)
- One natural sub-module: dec_sel_lfsr4 (4-bit LFSR with advance enable and seed load-on-reset).
- The checker stays inline under the macro.

Test Plan:
- Reset mid-run: assert RSTB low during RUN -> all outputs 0 immediately (asynchronous). START after release -> clean restart with first code 00.
- MODE=00, DWELL=0, LEN=4, START -> IN1/IN2 = 00,01,10,11 on cycles 1..4. Cycle 5: DONE=1, VALID=0, STEP_CNT=4. Cycle 6: IDLE.
- MODE=01, DWELL=2, LEN=5 -> codes 00,01,11,10,00, each held 3 cycles. DONE at cycle 16.
- MODE=10, DWELL=1, LEN=0 -> codes 11,10,01,00,11..., each held 2 cycles, no DONE. STOP at cycle 9 -> cycle 10: VALID=0, IN=00, no DONE pulse.
- MODE=11, LFSR_SEED=1, DWELL=0, LEN=15 -> the 15-state maximal sequence appears on LFSR[1:0]. START pulsed during RUN -> ignored. START+STOP together in IDLE -> stays IDLE.
- With the check macro defined: drive Q_FB from the decoder model -> MISMATCH stays 0. Force Q_FB=4'b0001 while the code is 10 -> MISMATCH=1 one cycle later and stays 1 until the next accepted START.
